ram_port_arbiter: RTL

- Shares the single synchronous-read RAM port between instruction fetch (IF, read-only) and the memory stage (MEM, read/write).
- Performs 32-bit word lane steering on the 64-bit RAM bus, and uses a req/ack handshake so the pipeline can stall until its access completes.
- Sits between the fetch unit / mem_stage and the RAM model.

---
 rtl/ram_port_arbiter_pkg.sv | 26 ++
 rtl/ram_port_arbiter_steer.sv | 26 ++
 rtl/ram_port_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the RAM port arbiter and its lane steering helper.
package ram_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF     = 64;
  localparam int unsigned RAM_DW_DEF     = 64;
  localparam int unsigned DW_DEF         = 32;
  localparam int unsigned STARVE_MAX_DEF = 3;

  localparam int unsigned WORD_W = DW_DEF;
  localparam int unsigned RAM_W  = RAM_DW_DEF;

  localparam logic [RAM_W-1:0] LANE_HI_MASK = 64'hFFFF_FFFF_0000_0000;
  localparam logic [RAM_W-1:0] LANE_LO_MASK = 64'h0000_0000_FFFF_FFFF;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_e;

endpackage

// File: rtl/ram_port_arbiter_steer.sv
// word_lane_steer: places a 32-bit word on the addressed half of the 64-bit RAM bus
// and picks the addressed half of a RAM read word.
module word_lane_steer
  import ram_port_arbiter_pkg::*;
(
  input  logic              i_lane_hi,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [RAM_W-1:0]  i_rdata,
  output logic [RAM_W-1:0]  o_wdata,
  output logic [RAM_W-1:0]  o_wmask,
  output logic [WORD_W-1:0] o_rdata
);

  always_comb begin
    if (i_lane_hi) begin
      o_wdata = {i_wdata, {WORD_W{1'b0}}};
      o_wmask = LANE_HI_MASK;
      o_rdata = i_rdata[RAM_W-1:WORD_W];
    end else begin
      o_wdata = {{WORD_W{1'b0}}, i_wdata};
      o_wmask = LANE_LO_MASK;
      o_rdata = i_rdata[WORD_W-1:0];
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous-read RAM port between instruction fetch (read-only) and the
// memory stage (read/write), with req/ack handshakes and bounded IF starvation.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned RAM_DW     = RAM_DW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DW-1:0]     if_data_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DW-1:0]     mem_wdata_i,
  output logic              mem_ack_o,
  output logic [DW-1:0]     mem_rdata_o,
  output logic              ram_r_ena_o,
  output logic [ADDR_W-1:0] ram_r_addr_o,
  input  logic [RAM_DW-1:0] ram_r_data_i,
  output logic              ram_w_ena_o,
  output logic [ADDR_W-1:0] ram_w_addr_o,
  output logic [RAM_DW-1:0] ram_w_data_o,
  output logic [RAM_DW-1:0] ram_w_mask_o,
  output logic              busy_o
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  owner_e                r_owner;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DW-1:0]         r_wdata;
  logic [DW-1:0]         r_if_data;
  logic [DW-1:0]         r_mem_data;
  logic [STARVE_W-1:0]   r_starve_cnt;
  logic                  w_grant_if;
  logic                  w_grant_mem;
  logic [RAM_DW-1:0]     w_steer_wdata;
  logic [RAM_DW-1:0]     w_steer_wmask;
  logic [DW-1:0]         w_steer_rdata;

  word_lane_steer u_steer (
    .i_lane_hi (r_addr[2]),
    .i_wdata   (r_wdata),
    .i_rdata   (ram_r_data_i),
    .o_wdata   (w_steer_wdata),
    .o_wmask   (w_steer_wmask),
    .o_rdata   (w_steer_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ARB_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Arbitration, next state and all port outputs decoded from the latched access.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_if   = 1'b0;
    w_grant_mem  = 1'b0;
    if_ack_o     = 1'b0;
    mem_ack_o    = 1'b0;
    if_data_o    = r_if_data;
    mem_rdata_o  = r_mem_data;
    ram_r_ena_o  = 1'b0;
    ram_r_addr_o = '0;
    ram_w_ena_o  = 1'b0;
    ram_w_addr_o = '0;
    ram_w_data_o = '0;
    ram_w_mask_o = '0;
    busy_o       = (r_state != ARB_IDLE);
    case (r_state)
      ARB_IDLE: begin
        if (mem_req_i && !(if_req_i && (r_starve_cnt == STARVE_W'(STARVE_MAX)))) begin
          w_grant_mem = 1'b1;
        end else if (if_req_i) begin
          w_grant_if = 1'b1;
        end
        if (w_grant_mem || w_grant_if) w_state_nxt = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        if (r_we) begin
          ram_w_ena_o  = 1'b1;
          ram_w_addr_o = r_addr;
          ram_w_data_o = w_steer_wdata;
          ram_w_mask_o = w_steer_wmask;
          if_ack_o     = (r_owner == OWNER_IF);
          mem_ack_o    = (r_owner == OWNER_MEM);
          w_state_nxt  = ARB_IDLE;
        end else begin
          ram_r_ena_o  = 1'b1;
          ram_r_addr_o = r_addr;
          w_state_nxt  = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (r_owner == OWNER_IF) begin
          if_ack_o  = 1'b1;
          if_data_o = w_steer_rdata;
        end else begin
          mem_ack_o   = 1'b1;
          mem_rdata_o = w_steer_rdata;
        end
        w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Grant latching, starvation counter and delivered-word hold registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= OWNER_IF;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_starve_cnt <= '0;
      r_if_data    <= '0;
      r_mem_data   <= '0;
    end else begin
      if (w_grant_mem) begin
        r_owner <= OWNER_MEM;
        r_we    <= mem_we_i;
        r_addr  <= mem_addr_i;
        r_wdata <= mem_wdata_i;
        if (if_req_i && (r_starve_cnt != STARVE_W'(STARVE_MAX))) begin
          r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
        end
      end else if (w_grant_if) begin
        r_owner      <= OWNER_IF;
        r_we         <= 1'b0;
        r_addr       <= if_addr_i;
        r_wdata      <= '0;
        r_starve_cnt <= '0;
      end
      if (r_state == ARB_RESP) begin
        if (r_owner == OWNER_IF) r_if_data  <= w_steer_rdata;
        else                     r_mem_data <= w_steer_rdata;
      end
    end
  end

endmodule
